// File: rtl/uart_rxr.sv
// 8N1 UART receiver: double-flop synchronizer, mid-bit sampling, start/stop validation.
// Emits each good byte with a one-cycle valid strobe, or a one-cycle frame-error strobe.
module uart_rxr #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_dataline,
  output logic [7:0] o_byte,
  output logic       o_data_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    START_CHECK = 3'd1,
    DATA        = 3'd2,
    STOP        = 3'd3,
    CLEANUP     = 3'd4,
    WAIT_IDLE   = 3'd5
  } state_t;

  state_t          state, state_next;
  logic            sync1, rx_s;
  logic [CW-1:0]   clk_ctr, clk_ctr_next;
  logic [2:0]      bit_ctr, bit_ctr_next;
  logic [7:0]      shift_reg, shift_next;
  logic [7:0]      byte_next;
  logic            valid_next, err_next;

  // Synchronizer flops reset high so a reset never looks like a start edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= i_dataline;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      clk_ctr      <= '0;
      bit_ctr      <= '0;
      shift_reg    <= '0;
      o_byte       <= '0;
      o_data_valid <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      state        <= state_next;
      clk_ctr      <= clk_ctr_next;
      bit_ctr      <= bit_ctr_next;
      shift_reg    <= shift_next;
      o_byte       <= byte_next;
      o_data_valid <= valid_next;
      o_frame_err  <= err_next;
    end
  end

  always_comb begin
    state_next   = state;
    clk_ctr_next = clk_ctr;
    bit_ctr_next = bit_ctr;
    shift_next   = shift_reg;
    byte_next    = o_byte;
    valid_next   = o_data_valid;
    err_next     = o_frame_err;
    case (state)
      IDLE: begin
        clk_ctr_next = '0;
        bit_ctr_next = '0;
        if (!rx_s) state_next = START_CHECK;
      end
      START_CHECK: begin
        if (clk_ctr == HALF) begin
          clk_ctr_next = '0;
          // Re-sampling at mid start bit rejects short low glitches.
          state_next   = rx_s ? IDLE : DATA;
        end else begin
          clk_ctr_next = CW'(clk_ctr + 1'b1);
        end
      end
      DATA: begin
        if (clk_ctr == LAST) begin
          clk_ctr_next        = '0;
          shift_next[bit_ctr] = rx_s;
          if (bit_ctr == 3'd7) begin
            bit_ctr_next = '0;
            state_next   = STOP;
          end else begin
            bit_ctr_next = bit_ctr + 3'd1;
          end
        end else begin
          clk_ctr_next = CW'(clk_ctr + 1'b1);
        end
      end
      STOP: begin
        if (clk_ctr == LAST) begin
          clk_ctr_next = '0;
          if (rx_s) begin
            byte_next  = shift_reg;
            valid_next = 1'b1;
            state_next = CLEANUP;
          end else begin
            err_next   = 1'b1;
            state_next = WAIT_IDLE;
          end
        end else begin
          clk_ctr_next = CW'(clk_ctr + 1'b1);
        end
      end
      CLEANUP: begin
        valid_next = 1'b0;
        err_next   = 1'b0;
        state_next = IDLE;
      end
      WAIT_IDLE: begin
        // A held-low line (break) must go high before another start is accepted.
        err_next = 1'b0;
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rxr.sv
// Directed bench for uart_rxr: an 8-clock-per-bit instance for framing corner cases
// and a full byte sweep, plus a 434-clock-per-bit instance for a short loopback run.
module tb_uart_rxr;

  logic       clk;
  logic       rst;
  logic       line8;
  logic       line434;
  logic [7:0] byte8, byte434;
  logic       dv8, fe8, busy8;
  logic       dv434, fe434, busy434;

  int tests    = 0;
  int failures = 0;

  uart_rxr #(.CLKS_PER_BIT(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_dataline(line8),
    .o_byte(byte8), .o_data_valid(dv8), .o_frame_err(fe8), .o_busy(busy8)
  );

  uart_rxr #(.CLKS_PER_BIT(434)) dut434 (
    .i_clk(clk), .i_rst(rst), .i_dataline(line434),
    .o_byte(byte434), .o_data_valid(dv434), .o_frame_err(fe434), .o_busy(busy434)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor: collects received bytes and counts strobes and strobe-shape errors.
  logic [7:0] q8[$];
  logic [7:0] q434[$];
  int  dv_cnt = 0, fe_cnt = 0, fe434_cnt = 0;
  int  width_err = 0, both_err = 0;
  bit  busy_seen = 0;
  logic dv_prev = 0, fe_prev = 0;

  always @(negedge clk) begin
    if (dv8) begin
      q8.push_back(byte8);
      dv_cnt++;
    end
    if (fe8) fe_cnt++;
    if (dv434) q434.push_back(byte434);
    if (fe434) fe434_cnt++;
    if ((dv8 && dv_prev) || (fe8 && fe_prev)) width_err++;
    if ((dv8 && fe8) || (dv434 && fe434)) both_err++;
    if (busy8) busy_seen = 1;
    dv_prev = dv8;
    fe_prev = fe8;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic drive(input bit big, input logic v);
    if (big) line434 = v;
    else     line8   = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input bit big, input logic [7:0] data, input logic stop);
    int n;
    logic [9:0] frame;
    n     = big ? 434 : 8;
    frame = {stop, data, 1'b0};
    for (int b = 0; b < 10; b++) begin
      drive(big, frame[b]);
      idle(n);
    end
    drive(big, 1'b1);
  endtask

  task automatic expect8(input string tag, input logic [7:0] exp);
    logic [31:0] got;
    got = (q8.size() > 0) ? {24'h0, q8.pop_front()} : 32'hDEAD;
    check(tag, got, {24'h0, exp});
  endtask

  task automatic expect434(input string tag, input logic [7:0] exp);
    logic [31:0] got;
    got = (q434.size() > 0) ? {24'h0, q434.pop_front()} : 32'hDEAD;
    check(tag, got, {24'h0, exp});
  endtask

  int dv0, fe0;
  logic [7:0] lb_vec [4];

  initial begin
    rst = 1'b1; line8 = 1'b1; line434 = 1'b1;
    idle(3);
    check("reset_byte",  {24'h0, byte8}, 32'h0);
    check("reset_valid", {31'h0, dv8},   32'h0);
    check("reset_err",   {31'h0, fe8},   32'h0);
    check("reset_busy",  {31'h0, busy8}, 32'h0);
    rst = 1'b0;
    idle(5);

    // Single frame
    dv0 = dv_cnt; fe0 = fe_cnt;
    send(0, 8'hA5, 1'b1);
    idle(16);
    expect8("a5_byte", 8'hA5);
    check("a5_dv_count", dv_cnt - dv0, 1);
    check("a5_no_err",   fe_cnt - fe0, 0);
    check("a5_busy_low", {31'h0, busy8}, 32'h0);
    check("a5_obyte",    {24'h0, byte8}, 32'hA5);

    // Back-to-back frames, no idle between stop and next start
    dv0 = dv_cnt;
    send(0, 8'h00, 1'b1);
    send(0, 8'hFF, 1'b1);
    send(0, 8'h5A, 1'b1);
    idle(16);
    check("b2b_dv_count", dv_cnt - dv0, 3);
    expect8("b2b_00", 8'h00);
    expect8("b2b_ff", 8'hFF);
    expect8("b2b_5a", 8'h5A);

    // 2-clock glitch on idle line
    dv0 = dv_cnt; fe0 = fe_cnt; busy_seen = 0;
    line8 = 1'b0; idle(2); line8 = 1'b1;
    idle(20);
    check("glitch_busy_seen", {31'h0, busy_seen}, 32'h1);
    check("glitch_busy_low",  {31'h0, busy8}, 32'h0);
    check("glitch_no_dv",     dv_cnt - dv0, 0);
    check("glitch_no_err",    fe_cnt - fe0, 0);
    send(0, 8'h3C, 1'b1);
    idle(16);
    expect8("after_glitch_3c", 8'h3C);

    // Stop bit low, line held low 20 more clocks
    dv0 = dv_cnt; fe0 = fe_cnt;
    send(0, 8'hC3, 1'b0);
    line8 = 1'b0;
    idle(20);
    line8 = 1'b1;
    idle(16);
    check("ferr_count", fe_cnt - fe0, 1);
    check("ferr_no_dv", dv_cnt - dv0, 0);
    check("ferr_byte_kept", {24'h0, byte8}, 32'h3C);
    send(0, 8'h81, 1'b1);
    idle(16);
    expect8("after_ferr_81", 8'h81);

    // Reset during data bit 4 of 8'h7E (start + bits 0..3 + half of bit 4)
    dv0 = dv_cnt; fe0 = fe_cnt;
    line8 = 1'b0; idle(8);
    for (int b = 0; b < 4; b++) begin
      line8 = (8'h7E >> b) & 1'b1;
      idle(8);
    end
    line8 = 1'b1; idle(4);
    rst = 1'b1;
    #1;
    check("midrst_byte",  {24'h0, byte8}, 32'h0);
    check("midrst_valid", {31'h0, dv8},   32'h0);
    check("midrst_err",   {31'h0, fe8},   32'h0);
    check("midrst_busy",  {31'h0, busy8}, 32'h0);
    idle(3);
    rst = 1'b0;
    idle(16);
    check("midrst_no_dv", dv_cnt - dv0, 0);
    send(0, 8'h42, 1'b1);
    idle(16);
    expect8("after_rst_42", 8'h42);
    check("after_rst_no_err", fe_cnt - fe0, 0);

    // Line stuck low out of reset: exactly one frame error, then silence
    rst = 1'b1; line8 = 1'b0;
    idle(3);
    rst = 1'b0;
    dv0 = dv_cnt; fe0 = fe_cnt;
    idle(120);
    check("stuck_one_err", fe_cnt - fe0, 1);
    idle(200);
    check("stuck_still_one_err", fe_cnt - fe0, 1);
    check("stuck_busy", {31'h0, busy8}, 32'h1);
    check("stuck_no_dv", dv_cnt - dv0, 0);
    line8 = 1'b1;
    idle(16);
    check("stuck_released_idle", {31'h0, busy8}, 32'h0);

    // All 256 byte values back to back
    dv0 = dv_cnt; fe0 = fe_cnt;
    for (int i = 0; i < 256; i++) send(0, 8'(i), 1'b1);
    idle(16);
    check("sweep_dv_count", dv_cnt - dv0, 256);
    check("sweep_no_err",   fe_cnt - fe0, 0);
    for (int i = 0; i < 256; i++) expect8($sformatf("sweep_%02h", i), 8'(i));

    // Full-rate loopback at 434 clocks per bit
    lb_vec[0] = 8'h00; lb_vec[1] = 8'hFF; lb_vec[2] = 8'h55; lb_vec[3] = 8'hA3;
    for (int i = 0; i < 4; i++) send(1, lb_vec[i], 1'b1);
    idle(40);
    for (int i = 0; i < 4; i++) expect434($sformatf("lb434_%0d", i), lb_vec[i]);
    check("lb434_no_err", fe434_cnt, 0);
    check("lb434_busy_low", {31'h0, busy434}, 32'h0);

    check("strobe_width_err", width_err, 0);
    check("strobe_overlap_err", both_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
